// File: rtl/uart_tx.sv
// 8-bit LSB-first UART transmitter (start, 8 data, optional even parity, 1 stop).
// Define UART_TX_PARITY_EN to compile in the parity bit (8E1); otherwise 8N1.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       ready,
  output logic       txd
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic          txd_reg, txd_next;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_reg, par_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
      txd_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shreg_reg   <= shreg_next;
      txd_reg     <= txd_next;
`ifdef UART_TX_PARITY_EN
      par_reg     <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    txd_next     = txd_reg;
`ifdef UART_TX_PARITY_EN
    par_next     = par_reg;
`endif
    bit_end = (cnt_reg == CNT_LAST);

    // Baud counter runs in every non-idle state and wraps on the last cycle of a bit.
    if (state_reg != S_IDLE)
      cnt_next = bit_end ? '0 : cnt_reg + CW'(1);

    // txd_next is the level for the cycle after this edge, keeping txd glitch-free.
    case (state_reg)
      S_IDLE: begin
        txd_next = 1'b1;
        if (wr) begin
          shreg_next = din;
          cnt_next   = '0;
          state_next = S_START;
          txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_next   = ^din;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next   = S_DATA;
          bit_idx_next = 3'd0;
          txd_next     = shreg_reg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_next   = shreg_reg >> 1;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            txd_next   = par_reg;
`else
            state_next = S_STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            txd_next = shreg_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          txd_next   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_next = S_IDLE;
          txd_next   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // Combinational from wr so upstream never sees ready high while its own strobe is pending.
  assign ready = !reset && (state_reg == S_IDLE) && !wr;
  assign txd   = txd_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at DIV=16: directed cases plus random bytes,
// compared cycle by cycle against a frame-level model of the serial line.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic       txd;

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;

  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .ready (ready),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level for bit slot n of the frame carrying byte b (slot 0 = start bit).
  function automatic logic frame_bit(input logic [7:0] b, input int n);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {2'b11, b, 1'b0};
`endif
    return f[n];
  endfunction

  // Waits for ready, issues one wr pulse, then checks every cycle of the frame.
  // busy_at: frame cycle at which to pulse a stray wr (0xFF); abort_at: cycle to assert reset.
  task automatic send_frame(input logic [7:0] b, input int busy_at, input int abort_at);
    int pass0;
    pass0 = n_pass;
    for (int i = 0; i < 4 * FRAME_BITS * DIV && ready !== 1'b1; i++) step();
    check("ready_wait", ready, 1'b1);
    wr  = 1'b1;
    din = b;
    #1;
    check("ready_in_wr_cycle", ready, 1'b0);
    step();
    wr  = 1'b0;
    din = 8'($urandom);
    for (int k = 0; k < FRAME_BITS * DIV; k++) begin
      if (k == busy_at) begin
        wr  = 1'b1;
        din = 8'hFF;
        #1;
      end
      check("txd", txd, frame_bit(b, k / DIV));
      check("ready_busy", ready, 1'b0);
      if (k == abort_at) begin
        reset = 1'b1;
        step();
        check("txd_after_abort", txd, 1'b1);
        check("ready_in_reset", ready, 1'b0);
        reset = 1'b0;
        #1;
        check("ready_after_abort", ready, 1'b1);
        $display("frame %0d byte 0x%02h aborted at cycle %0d: %0d checks ok", n_frames, b, k, n_pass - pass0);
        n_frames++;
        return;
      end
      step();
      wr  = 1'b0;
      din = 8'($urandom);
    end
    check("ready_after_frame", ready, 1'b1);
    check("txd_idle", txd, 1'b1);
    $display("frame %0d byte 0x%02h: %0d checks ok", n_frames, b, n_pass - pass0);
    n_frames++;
  endtask

  initial begin
    string msg;
    msg = "Game End: ";

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_txd", txd, 1'b1);
      check("reset_ready", ready, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("ready_after_reset", ready, 1'b1);
    check("txd_after_reset", txd, 1'b1);

    // Single byte, then a stray write during DATA followed by idle-line checks
    send_frame(8'h47, -1, -1);
    send_frame(8'h47, 3 * DIV + 2, -1);
    for (int i = 0; i < 2 * DIV; i++) begin
      check("no_extra_frame_txd", txd, 1'b1);
      check("no_extra_frame_ready", ready, 1'b1);
      step();
    end

    // Reset during bit 3, then a clean byte and a parity-1 byte
    send_frame(8'h31, -1, 4 * DIV + 5);
    send_frame(8'h32, -1, -1);
    send_frame(8'h31, -1, -1);

    // Back-to-back upstream handshake
    for (int i = 0; i < msg.len(); i++) send_frame(8'(msg[i]), -1, -1);

    // Simultaneous reset and wr: byte must not be taken
    reset = 1'b1;
    wr    = 1'b1;
    din   = 8'h55;
    step();
    reset = 1'b0;
    wr    = 1'b0;
    #1;
    check("rst_wr_ready", ready, 1'b1);
    step();
    check("rst_wr_txd", txd, 1'b1);
    $display("reset+wr collision: byte 0x55 dropped as expected check done");

    // Random bytes with random idle gaps
    for (int n = 0; n < 8; n++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        check("gap_txd", txd, 1'b1);
        step();
      end
      send_frame(8'($urandom), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
